// File: rtl/tile_field_pkg.sv
// Shared types and colour constants for the tile field engine.
// No logic, so no latency.
// No flow control.
package tile_field_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   // 12-bit {R,G,B} colours, 4 bits per channel
   localparam logic [11:0] C_BLANK  = 12'h000;
   localparam logic [11:0] C_BORDER = 12'h888;
   localparam logic [11:0] C_BLACK  = 12'h000;
   localparam logic [11:0] C_HIT    = 12'h44F;
   localparam logic [11:0] C_WHITE  = 12'hFFF;

endpackage

// File: rtl/tile_field_if.sv
// Key-press handshake between the player input source and the tile field engine.
// Combinational: key_ready reflects engine state in the same cycle.
// A key is taken only on key_valid & key_ready; the source holds or drops it otherwise.
// Ports: key_valid/key_lane (source -> engine), key_ready (engine -> source).
interface tile_field_if #(
   parameter int LANE_IDX_W = 3
);
   logic                  key_valid;
   logic [LANE_IDX_W-1:0] key_lane;
   logic                  key_ready;

   modport master (output key_valid, output key_lane, input key_ready);
   modport slave  (input key_valid, input key_lane, output key_ready);
endinterface

// File: rtl/tile_field_pixel.sv
// Classifies the current pixel against the tile field and registers its colour.
// Latency: one CLK from draw_x/draw_y/blank (and field state) to pix_rgb.
// No backpressure: samples every cycle.
// Ports: CLK, RESET; draw_x, draw_y, blank (video position); offset, mask, cleared,
//        incoming (field state from the engine); pix_rgb (registered colour).
module tile_field_pixel
   import tile_field_pkg::*;
#(
   parameter int NUM_LANES = 5,
   parameter int NUM_ROWS  = 4,
   parameter int ROW_H     = 120,
   parameter int LANE_W    = 128
) (
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic [9:0]                         draw_x,
   input  logic [9:0]                         draw_y,
   input  logic                               blank,
   input  logic [9:0]                         offset,
   input  logic [NUM_ROWS-1:0][NUM_LANES-1:0] mask,
   input  logic [NUM_ROWS-1:0]                cleared,
   input  logic [NUM_LANES-1:0]               incoming,
   output logic [11:0]                        pix_rgb
);

   int          yy;
   int          ty;
   int          tx;
   int          row;
   int          lane;
   logic        black;
   logic        tile_hit;
   logic        border;
   logic [11:0] pix_d;

   always_comb begin
      yy   = int'(draw_y) - int'(offset);
      lane = int'(draw_x) / LANE_W;
      tx   = int'(draw_x) % LANE_W;
      // Above row 0 is the incoming row, one tile height tall; its local y is
      // measured from its own top edge so its borders line up with the rows below.
      if (yy < 0) begin
         row = -1;
         ty  = yy + ROW_H;
      end else begin
         row = yy / ROW_H;
         ty  = yy % ROW_H;
      end
      border = (tx == 0) || (tx == LANE_W - 1) || (ty == 0) || (ty == ROW_H - 1);

      // Lanes past the field and rows below the bottom row stay white.
      black    = 1'b0;
      tile_hit = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (lane == l) begin
            if (row < 0) black = incoming[l];
            for (int r = 0; r < NUM_ROWS; r++) begin
               if (row == r) begin
                  black    = mask[r][l];
                  tile_hit = cleared[r];
               end
            end
         end
      end

      if (!blank)                 pix_d = C_BLANK;
      else if (border)            pix_d = C_BORDER;
      else if (black && tile_hit) pix_d = C_HIT;
      else if (black)             pix_d = C_BLACK;
      else                        pix_d = C_WHITE;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) pix_rgb <= C_BLANK;
      else       pix_rgb <= pix_d;
   end

endmodule

// File: rtl/tile_field_engine.sv
// Scrolling piano-tile game field: row store, scroll, hit/miss scoring, pixel render.
// Latency: key/frame effects visible one CLK later; pix_rgb one CLK after draw inputs.
// Backpressure: key_ready high only while a game runs; one key accepted per cycle.
// Ports: CLK, RESET (async, active-high); frame_tick, start, speed, rand_in; key
//        (tile_field_if slave: key_valid, key_lane, key_ready); draw_x, draw_y, blank;
//        pix_rgb, score, game_over.
// Build option: TILE_FIELD_AUTOSPEED_EN adds score[15:4] to the scroll step (saturating).
module tile_field_engine
   import tile_field_pkg::*;
#(
   parameter int NUM_LANES = 5,
   parameter int NUM_ROWS  = 4,
   parameter int ROW_H     = 120,
   parameter int LANE_W    = 128,
   parameter int SPEED_W   = 3
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               frame_tick,
   input  logic               start,
   input  logic [SPEED_W-1:0] speed,
   input  logic [7:0]         rand_in,
   tile_field_if.slave        key,
   input  logic [9:0]         draw_x,
   input  logic [9:0]         draw_y,
   input  logic               blank,
   output logic [11:0]        pix_rgb,
   output logic [15:0]        score,
   output logic               game_over
);

   localparam int BOT      = NUM_ROWS - 1;
   localparam int STEP_MAX = (1 << SPEED_W) - 1;

   function automatic logic [NUM_LANES-1:0] onehot(input int idx);
      logic [NUM_LANES-1:0] v;
      v = '0;
      for (int l = 0; l < NUM_LANES; l++) if (l == idx) v[l] = 1'b1;
      return v;
   endfunction

   function automatic logic [NUM_ROWS-1:0][NUM_LANES-1:0] init_mask();
      logic [NUM_ROWS-1:0][NUM_LANES-1:0] m;
      for (int r = 0; r < NUM_ROWS; r++) m[r] = onehot(r % NUM_LANES);
      return m;
   endfunction

   localparam logic [NUM_ROWS-1:0][NUM_LANES-1:0] MASK_INIT = init_mask();
   localparam logic [NUM_LANES-1:0]               INC_INIT  = onehot(NUM_ROWS % NUM_LANES);

   state_t                             state_q;
   state_t                             state_d;
   logic [NUM_ROWS-1:0][NUM_LANES-1:0] mask;      // row 0 = top
   logic [NUM_ROWS-1:0]                cleared;
   logic [NUM_LANES-1:0]               incoming;
   logic [9:0]                         offset;

   logic key_acc;
   logic lane_black;
   logic hit;
   logic shift;
   logic miss;
   logic restart;
   logic advance;
   int   step;
   int   offset_sum;
   int   rand_lane;

   assign key.key_ready = (state_q == ST_RUN);
   assign game_over     = (state_q == ST_OVER);

   // Out-of-range lane numbers match no lane and therefore count as a miss.
   always_comb begin
      lane_black = 1'b0;
      for (int l = 0; l < NUM_LANES; l++)
         if (int'(key.key_lane) == l) lane_black = mask[BOT][l];
   end

   always_comb begin
      step = int'(speed);
`ifdef TILE_FIELD_AUTOSPEED_EN
      step = int'(speed) + int'(score[15:4]);
      if (step > STEP_MAX) step = STEP_MAX;
`endif
   end

   assign key_acc    = key.key_valid & key.key_ready;
   assign hit        = key_acc & lane_black & ~cleared[BOT];
   assign offset_sum = int'(offset) + step;
   assign shift      = frame_tick && (offset_sum >= ROW_H);
   assign rand_lane  = int'(rand_in) % NUM_LANES;
   // A hit in the shift cycle is judged on the pre-shift bottom row and saves it.
   assign miss       = (key_acc & ~hit) | (shift & ~cleared[BOT] & ~hit);
   assign restart    = start && (state_q != ST_RUN);
   // The miss cycle freezes the field: the game ends on the pre-miss state.
   assign advance    = (state_q == ST_RUN) && !miss;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_OVER: if (start) state_d = ST_RUN;
         ST_RUN:           if (miss)  state_d = ST_OVER;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mask     <= MASK_INIT;
         cleared  <= '0;
         incoming <= INC_INIT;
         offset   <= '0;
         score    <= '0;
      end else if (restart) begin
         mask     <= MASK_INIT;
         cleared  <= '0;
         incoming <= INC_INIT;
         offset   <= '0;
         score    <= '0;
      end else if (advance) begin
         if (hit) begin
            cleared[BOT] <= 1'b1;
            if (score != 16'hFFFF) score <= score + 16'd1;
         end
         if (frame_tick) begin
            if (shift) begin
               // Whole-vector writes here supersede the cleared[BOT] set above.
               offset   <= 10'(offset_sum - ROW_H);
               mask     <= {mask[NUM_ROWS-2:0], incoming};
               cleared  <= {cleared[NUM_ROWS-2:0], 1'b0};
               incoming <= onehot(rand_lane);
            end else begin
               offset <= 10'(offset_sum);
            end
         end
      end
   end

   tile_field_pixel #(
      .NUM_LANES (NUM_LANES),
      .NUM_ROWS  (NUM_ROWS),
      .ROW_H     (ROW_H),
      .LANE_W    (LANE_W)
   ) u_pixel (
      .CLK      (CLK),
      .RESET    (RESET),
      .draw_x   (draw_x),
      .draw_y   (draw_y),
      .blank    (blank),
      .offset   (offset),
      .mask     (mask),
      .cleared  (cleared),
      .incoming (incoming),
      .pix_rgb  (pix_rgb)
   );

endmodule

// File: doc/tile_field_engine.md
TILE_FIELD_ENGINE -- requirements
Module: tile_field_engine

Interface
REQ-001 SHALL have parameter NUM_LANES, default 5: tile lanes across the screen, 2..8.
REQ-002 SHALL have parameter NUM_ROWS, default 4: resident tile rows, 2..8.
REQ-003 SHALL have parameter ROW_H, default 120: tile height in pixels.
REQ-004 SHALL have parameter LANE_W, default 128: tile width in pixels.
REQ-005 SHALL have parameter SPEED_W, default 3: width of the scroll-step input.
REQ-006 SHALL have port CLK, input, 1: clock.
REQ-007 SHALL have port RESET, input, 1: reset (asynchronous, active-high).
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse per frame, synchronous to CLK.
REQ-009 SHALL have port start, input, 1: begin a game.
REQ-010 SHALL have port speed, input, SPEED_W: pixels scrolled per frame.
REQ-011 SHALL have port rand_in, input, 8: random source.
REQ-012 SHALL have port key_valid, input, 1: key press request.
REQ-013 SHALL have port key_lane, input, $clog2(NUM_LANES): pressed lane.
REQ-014 SHALL have port key_ready, output, 1: key accepted this cycle.
REQ-015 SHALL have port draw_x / draw_y, input, 10 each: current pixel.
REQ-016 SHALL have port blank, input, 1: active-video when high.
REQ-017 SHALL have port pix_rgb, output, 12: registered {R,G,B} 4 bits each.
REQ-018 SHALL have port score, output, 16: hit count.
REQ-019 SHALL have port game_over, output, 1: game ended, held until start or reset.

Function
REQ-020 SHALL implement FSM IDLE -> RUN on start; RUN -> OVER on a miss; OVER -> RUN on start; start in RUN ignored.
REQ-021 SHALL hold per row a NUM_LANES-bit black mask plus a cleared bit; SHALL hold the incoming row; row 0 is at the top and row NUM_ROWS-1 is the bottom row.
REQ-022 SHALL, in RUN on frame_tick: offset' = offset + step; if offset' >= ROW_H, then offset <= offset' - ROW_H, rows shift down one, row 0 <= incoming, and incoming <= 1 << (rand_in % NUM_LANES).
REQ-023 SHALL treat a shift that evicts a bottom row with cleared=0 as a miss.
REQ-024 SHALL assert key_ready only in RUN; SHALL accept a key on key_valid & key_ready, one key per cycle.
REQ-025 SHALL, on an accepted key, evaluate the bottom row: black lane and not cleared -> cleared <= 1 and score+1 (saturating at 0xFFFF); any other case is a miss.
REQ-026 SHALL evaluate a key that arrives in the same cycle as a shift against the pre-shift bottom row; a hit in that cycle rescues that row from the eviction miss.
REQ-027 SHALL freeze scrolling, rows, and score in IDLE and OVER; SHALL reset rows, offset, and score on start.
REQ-028 SHALL compute pixel position as yy = draw_y - offset (signed); yy < 0 selects incoming; otherwise row = yy / ROW_H; lane = draw_x / LANE_W; lanes >= NUM_LANES render white.
REQ-029 SHALL register pix_rgb one CLK after inputs with priority: blank low -> 0x000; tile border (x%LANE_W in {0,LANE_W-1} or yy%ROW_H in {0,ROW_H-1}) -> 0x888; cleared black tile -> 0x44F; black tile -> 0x000; else -> 0xFFF.

Reset
REQ-030 SHALL on RESET set: state IDLE, offset 0, score 0, game_over 0, key_ready 0, pix_rgb 0x000, row r mask = 1 << (r % NUM_LANES), cleared 0, incoming = 1 << (NUM_ROWS % NUM_LANES).
REQ-031 SHALL abort any mid-game state on RESET; there are no partial updates.

Configuration
REQ-032 SHALL, with TILE_FIELD_AUTOSPEED_EN defined, use step = min(speed + score[15:4], 2^SPEED_W - 1); without it, step = speed.

Structure
REQ-033 SHALL define in package tile_field_pkg: FSM state enum and color constants (C_BORDER, C_BLACK, C_HIT, C_WHITE).
REQ-034 SHALL place pixel classification and the output register in sub-module tile_field_pixel.

Verification
REQ-035 Reset, then frame_tick x5 without start -> offset 0, score 0, pix_rgb 0x000 while blank low.
REQ-036 start, speed=4, 30 frame_ticks -> exactly one shift; incoming = 1 << (rand_in%5); offset 0.
REQ-037 After the shift, key on the bottom row's black lane -> score 1, pixel at that tile renders 0x44F; a second press on the same lane -> game_over 1.
REQ-038 Key on a white lane -> game_over 1, key_ready 0 on the next cycle, score unchanged.
REQ-039 Hit in the same cycle as a shift -> no miss, score+1; no hit -> game_over at that shift.
REQ-040 With TILE_FIELD_AUTOSPEED_EN, score 32, speed 5 -> step 7 (saturated).
